// File: rtl/dm_timer_responder.sv
// Memory-mapped timer that answers the CPU data-memory bus.
// It decodes a 32-byte window at BASE_ADDR and provides a prescaled 32-bit
// down-counter with one-shot or auto-reload operation and a level interrupt.
// Reads are combinational (zero wait states). Writes commit on the rising clock edge.
module dm_timer_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_4000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        dm_cs,
    input  logic        dm_r,
    input  logic        dm_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_LOAD     = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    // The run state is the CTRL.en bit.
    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t                state;
    logic                  auto_reload;
    logic                  irq_en;
    logic                  expired;
    logic [31:0]           load;
    logic [31:0]           count;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_cnt;

    logic [2:0] offset;
    logic       sel;
    logic       wr_en;
    logic       rd_en;
    logic       ctrl_wr;
    logic       load_wr;
    logic       count_wr;
    logic       status_clr;
    logic       prescale_wr;
    logic       tick;
    logic       tick_live;
    logic       expire;
    logic       reload_sel;
    logic       stop_now;
    logic       unused_addr_bits;

    // Address decode. The byte-lane bits are ignored because only word accesses exist.
    assign hit              = (addr[31:5] == BASE_ADDR[31:5]);
    assign offset           = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];

    assign sel   = dm_cs & hit;
    assign wr_en = sel & dm_w;
    assign rd_en = sel & dm_r;

    assign ctrl_wr     = wr_en && (offset == OFF_CTRL);
    assign load_wr     = wr_en && (offset == OFF_LOAD);
    assign count_wr    = wr_en && (offset == OFF_COUNT);
    assign status_clr  = wr_en && (offset == OFF_STATUS) && wdata[0];
    assign prescale_wr = wr_en && (offset == OFF_PRESCALE);

    // A tick is discarded when software stops the timer or overwrites COUNT in the same cycle.
    assign tick       = (state == RUNNING) && (pre_cnt == prescale);
    assign tick_live  = tick && !(ctrl_wr && !wdata[0]) && !count_wr;
    assign expire     = tick_live && (count == 32'd0);
    // An expiry coinciding with a CTRL write obeys the newly written mode bit.
    assign reload_sel = ctrl_wr ? wdata[1] : auto_reload;
    assign stop_now   = (ctrl_wr && !wdata[0]) || (expire && !reload_sel);

    assign irq = expired & irq_en;

    // Register file, run/stop FSM, prescaler and down-counter.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state       <= STOPPED;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            expired     <= 1'b0;
            load        <= 32'd0;
            count       <= 32'd0;
            prescale    <= '0;
            pre_cnt     <= '0;
        end else begin
            case (state)
                STOPPED: begin
                    pre_cnt <= '0;
                    if (ctrl_wr && wdata[0]) begin
                        state <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (stop_now) begin
                        state   <= STOPPED;
                        pre_cnt <= '0;
                    end else if (tick) begin
                        pre_cnt <= '0;
                    end else begin
                        pre_cnt <= pre_cnt + PRE_ONE;
                    end
                end
                default: begin
                    state   <= STOPPED;
                    pre_cnt <= '0;
                end
            endcase

            if (ctrl_wr) begin
                auto_reload <= wdata[1];
                irq_en      <= wdata[2];
            end

            if (load_wr) begin
                load <= wdata;
            end

            if (prescale_wr) begin
                prescale <= wdata[PRESCALE_W-1:0];
            end

            if (count_wr) begin
                count <= wdata;
            end else if (tick_live) begin
                if (count != 32'd0) begin
                    count <= count - 32'd1;
                end else if (reload_sel) begin
                    count <= load;
                end
            end

            // Setting on expiry beats a simultaneous write-1-to-clear.
            if (expire) begin
                expired <= 1'b1;
            end else if (status_clr) begin
                expired <= 1'b0;
            end
        end
    end

    // Read mux; drives zero whenever the access is not a qualified read.
    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            case (offset)
                OFF_CTRL:     rdata = {29'd0, irq_en, auto_reload, (state == RUNNING)};
                OFF_LOAD:     rdata = load;
                OFF_COUNT:    rdata = count;
                OFF_STATUS:   rdata = {31'd0, expired};
                OFF_PRESCALE: rdata = 32'(prescale);
                default:      rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_timer_responder.sv
// Bench for dm_timer_responder: directed steps plus a randomized bus phase,
// all checked against a behavioural model of the timer's register rules.
module tb_dm_timer_responder;

    localparam logic [31:0] BASE = 32'h1001_4000;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        dm_cs  = 1'b0;
    logic        dm_r   = 1'b0;
    logic        dm_w   = 1'b0;
    logic [31:0] addr   = 32'd0;
    logic [31:0] wdata  = 32'd0;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    dm_timer_responder #(
        .BASE_ADDR (BASE),
        .PRESCALE_W(16)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .dm_cs (dm_cs),
        .dm_r  (dm_r),
        .dm_w  (dm_w),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .hit   (hit),
        .irq   (irq)
    );

    // Behavioural model state
    logic        m_en, m_ar, m_ie, m_exp;
    logic [31:0] m_load, m_count;
    logic [15:0] m_psc, m_pre;

    logic [31:0] last_rd;
    logic        last_hit;
    logic        last_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
        m_load = 0; m_count = 0; m_psc = 0; m_pre = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return {29'd0, m_ie, m_ar, m_en};
            3'd1:    return m_load;
            3'd2:    return m_count;
            3'd3:    return {31'd0, m_exp};
            3'd4:    return {16'd0, m_psc};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the timer, stated as the register rules.
    task automatic model_step(input logic cs, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic        wr, tick, ctrl_w, cnt_w;
        logic [2:0]  off;
        logic        n_en, n_ar, n_ie, n_exp;
        logic [31:0] n_load, n_count;
        logic [15:0] n_psc, n_pre;
        wr     = cs && w && (a[31:5] == BASE[31:5]);
        off    = a[4:2];
        ctrl_w = wr && (off == 3'd0);
        cnt_w  = wr && (off == 3'd2);
        tick   = m_en && (m_pre == m_psc);
        n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_exp = m_exp;
        n_load = m_load; n_count = m_count; n_psc = m_psc;
        if (wr) begin
            case (off)
                3'd0: begin n_en = d[0]; n_ar = d[1]; n_ie = d[2]; end
                3'd1: n_load = d;
                3'd2: n_count = d;
                3'd3: if (d[0]) n_exp = 0;
                3'd4: n_psc = d[15:0];
                default: ;
            endcase
        end
        if (tick && !(ctrl_w && !d[0]) && !cnt_w) begin
            if (m_count != 0) n_count = m_count - 1;
            else begin
                n_exp = 1;
                if (n_ar) n_count = m_load;
                else n_en = 0;
            end
        end
        if (!m_en || !n_en) n_pre = 0;
        else if (tick) n_pre = 0;
        else n_pre = m_pre + 16'd1;
        m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_exp = n_exp;
        m_load = n_load; m_count = n_count; m_psc = n_psc; m_pre = n_pre;
    endtask

    // Drive one bus cycle, check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic cs, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp_rd;
        dm_cs = cs; dm_r = r; dm_w = w; addr = a; wdata = d;
        @(negedge clk_in);
        check("hit", 32'(hit), 32'(a[31:5] == BASE[31:5]));
        check("irq", 32'(irq), 32'(m_exp && m_ie));
        exp_rd = (cs && r && (a[31:5] == BASE[31:5])) ? model_read(a[4:2]) : 32'd0;
        check("rdata", rdata, exp_rd);
        last_rd = rdata; last_hit = hit; last_irq = irq;
        @(posedge clk_in);
        if (reset) model_step(cs, w, a, d);
        else model_reset();
        #1;
        dm_cs = 0; dm_r = 0; dm_w = 0;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        cyc(1, 0, 1, BASE + 32'(off * 4), d);
    endtask

    task automatic rd(input int off);
        cyc(1, 1, 0, BASE + 32'(off * 4), 32'd0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'd0, 32'd0);
    endtask

    int          first_seen, prev_seen, n_exp_seen;
    logic [31:0] frozen;
    logic [31:0] ra, rd_val;
    logic        rcs, rr, rw;

    initial begin
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        // Reset state
        for (int i = 0; i < 8; i++) begin
            rd(i);
            check("reset_read", last_rd, 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(i);
            check("post_reset_read", last_rd, 32'd0);
        end
        check("post_reset_irq", 32'(last_irq), 32'd0);
        cyc(1, 1, 0, 32'h1001_0000, 32'd0);
        check("miss_hit", 32'(last_hit), 32'd0);
        check("miss_rdata", last_rd, 32'd0);

        // One-shot countdown with interrupt
        wr(1, 3); wr(2, 3); wr(4, 0); wr(0, 5);
        rd(2); check("oneshot_cnt3", last_rd, 32'd3);
        rd(2); check("oneshot_cnt2", last_rd, 32'd2);
        rd(2); check("oneshot_cnt1", last_rd, 32'd1);
        rd(2); check("oneshot_cnt0", last_rd, 32'd0);
        rd(3); check("oneshot_status", last_rd, 32'd1);
        check("oneshot_irq", 32'(last_irq), 32'd1);
        rd(0); check("oneshot_ctrl", last_rd, 32'd4);
        wr(3, 1);
        rd(3); check("w1c_status", last_rd, 32'd0);
        check("w1c_irq", 32'(last_irq), 32'd0);

        // Auto-reload period (LOAD+1)*(PRESCALE+1)
        wr(1, 1); wr(4, 2); wr(2, 1); wr(0, 3);
        first_seen = -1; prev_seen = -1; n_exp_seen = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1, 1, 1, BASE + 32'hC, 32'd1);
            if (last_rd[0]) begin
                if (prev_seen < 0) first_seen = i;
                else check("reload_period", 32'(i - prev_seen), 32'((1 + 1) * (2 + 1)));
                prev_seen = i;
                n_exp_seen++;
            end
        end
        check("reload_first", 32'(first_seen), 32'd6);
        check("reload_count", 32'(n_exp_seen), 32'd4);
        wr(0, 2);
        rd(2); frozen = last_rd;
        idle(); idle(); idle();
        rd(2); check("freeze_count", last_rd, frozen);
        rd(0); check("freeze_ctrl", last_rd, 32'd2);

        // COUNT write beats a decrement
        wr(4, 0); wr(1, 32'h100); wr(2, 32'h50); wr(0, 3);
        idle(); idle();
        wr(2, 32'h10);
        rd(2); check("count_write_wins", last_rd, 32'h10);

        // Expiry beats W1C; CTRL write picks the mode of a coincident expiry
        wr(0, 0); wr(3, 1); wr(1, 0); wr(2, 0); wr(0, 3);
        idle();
        wr(3, 1);
        rd(3); check("set_beats_clear", last_rd, 32'd1);
        wr(0, 1);
        rd(0); check("new_mode_expiry", last_rd, 32'd0);

        // Asynchronous reset mid-count
        wr(3, 1); wr(1, 32'h100); wr(4, 0); wr(2, 32'h20); wr(0, 7);
        idle(); idle(); idle();
        reset = 1'b0;
        model_reset();
        dm_cs = 1; dm_r = 1; addr = BASE + 32'h8;
        #2;
        check("async_count", rdata, 32'd0);
        check("async_irq", 32'(irq), 32'd0);
        addr = BASE;
        #1;
        check("async_ctrl", rdata, 32'd0);
        @(posedge clk_in); #1;
        rd(2); rd(0);
        reset = 1'b1;
        cyc(0, 0, 1, BASE, 32'd7);
        rd(0); check("cs_low_write", last_rd, 32'd0);
        cyc(1, 0, 1, 32'h1001_0000, 32'd7);
        rd(0); check("miss_write", last_rd, 32'd0);

        // Randomized bus traffic
        for (int i = 0; i < 1500; i++) begin
            rcs = ($urandom_range(0, 9) != 0);
            rr  = 1'($urandom_range(0, 1));
            rw  = ($urandom_range(0, 2) == 0);
            ra  = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) ra = $urandom;
            rd_val = $urandom;
            case (ra[4:2])
                3'd1, 3'd2: rd_val = rd_val & 32'h0000_000F;
                3'd4:       rd_val = rd_val & 32'hFFFF_0003;
                3'd0:       if ($urandom_range(0, 1) == 1) rd_val = rd_val | 32'h1;
                default: ;
            endcase
            cyc(rcs, rr, rw, ra, rd_val);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
